// File: rtl/fpu_col_sequencer_if.sv
// Column-fetch and compute handshake bundle between the sequencer, the read port,
// the column buffers and the compute core.
interface fpu_col_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 10
);
  logic              col_req;
  logic [ADDR_W-1:0] col_addr;
  logic              col_ack;
  logic              shift_rows;
  logic              calc_start;
  logic              calc_done;
  logic [CNT_W-1:0]  out_col;

  modport master (
    output col_req, col_addr, shift_rows, calc_start, out_col,
    input  col_ack, calc_done
  );

  modport slave (
    input  col_req, col_addr, shift_rows, calc_start, out_col,
    output col_ack, calc_done
  );
endinterface

// File: rtl/fpu_col_sequencer.sv
// Walks the 3-column filter window across one strip: fills three columns, then alternates
// compute and single-column fetches until every column of the strip has been consumed.
module fpu_col_sequencer #(
  parameter int unsigned ROWS   = 10,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_cols,
  fpu_col_sequencer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StFill, StCalc, StFetch, StFin} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cols_q;
  logic [CNT_W-1:0]  fc_q;
  logic [CNT_W-1:0]  out_col_q;
  logic [ADDR_W-1:0] col_addr_q;
  logic              col_req_q;
  logic              calc_start_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cols_q       <= '0;
      fc_q         <= '0;
      out_col_q    <= '0;
      col_addr_q   <= '0;
      col_req_q    <= 1'b0;
      calc_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      calc_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q   <= StIdle;
        col_req_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              cols_q     <= cfg_cols;
              fc_q       <= '0;
              out_col_q  <= '0;
              col_addr_q <= cfg_base;
              busy_q     <= 1'b1;
              if (cfg_cols < CNT_W'(3)) begin
                state_q <= StFin;
              end else begin
                state_q   <= StFill;
                col_req_q <= 1'b1;
              end
            end
          end
          StFill: begin
            // Address advances by one column per accepted ack; wraps at ADDR_W.
            if (bus.col_ack) begin
              fc_q       <= fc_q + CNT_W'(1);
              col_addr_q <= col_addr_q + ADDR_W'(ROWS);
              if (fc_q == CNT_W'(2)) begin
                state_q      <= StCalc;
                col_req_q    <= 1'b0;
                calc_start_q <= 1'b1;
              end
            end
          end
          StCalc: begin
            if (bus.calc_done) begin
              if (fc_q == cols_q) begin
                state_q <= StFin;
              end else begin
                out_col_q <= out_col_q + CNT_W'(1);
                state_q   <= StFetch;
                col_req_q <= 1'b1;
              end
            end
          end
          StFetch: begin
            if (bus.col_ack) begin
              fc_q         <= fc_q + CNT_W'(1);
              col_addr_q   <= col_addr_q + ADDR_W'(ROWS);
              state_q      <= StCalc;
              col_req_q    <= 1'b0;
              calc_start_q <= 1'b1;
            end
          end
          StFin: begin
            done_q  <= 1'b1;
            err_q   <= (cols_q < CNT_W'(3));
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            state_q   <= StIdle;
            col_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.col_req    = col_req_q;
  assign bus.col_addr   = col_addr_q;
  assign bus.shift_rows = col_req_q && bus.col_ack;
  assign bus.calc_start = calc_start_q;
  assign bus.out_col    = out_col_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
